// File: rtl/alu_pkg.sv
// Shared definitions for the SimpleALU datapath blocks.
//   ser_state_e   : serial adder control states
//   SER_ADD_WIDTH : default operand width of the serial adder
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } ser_state_e;

  localparam int unsigned SER_ADD_WIDTH = 4;

endpackage

// File: rtl/serial_adder_fa.sv
// full_adder_cell: single-bit combinational full adder.
//   a, b, cin : addend bits and carry in
//   s         : sum bit
//   cout      : carry out (majority of the three inputs)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, LSB first, one full_adder_cell reused
// for N cycles. Valid/ready handshake on both the operand and result sides.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   a_i, b_i, cin_i : operands and carry in, sampled when valid_i & ready_o
//   valid_i/ready_o : operand handshake (ready_o high only in IDLE)
//   sum_o           : A+B+cin modulo 2^N
//   cout_o          : carry out of bit N-1
//   sign_o          : sum_o[N-1]
//   valid_o/ready_i : result handshake (result held while ready_i low)
//   ovf_o           : signed overflow, present only with SERIAL_ADDER_OVF_EN
module serial_adder
  import alu_pkg::*;
#(
  parameter int unsigned N = SER_ADD_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         sign_o,
  output logic         valid_o,
  input  logic         ready_i
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf_o
`endif
);

  localparam int unsigned CW = $clog2(N + 1);

  ser_state_e     state, next_state;
  logic [CW-1:0]  count;
  logic [N-1:0]   a_sr, b_sr, sum_sr, sum_nxt;
  logic           carry;
  logic           fa_s, fa_c;
  logic           accept;
  logic           last_bit;

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign accept   = valid_i && (state == IDLE);
  assign last_bit = (state == SHIFT) && (count == CW'(N - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid_i)  next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    if (ready_i)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
  end

  // New sum bit enters at the MSB so that after N shifts bit 0 sits at the LSB.
  always_comb begin
    sum_nxt        = sum_sr >> 1;
    sum_nxt[N-1]   = fa_s;
  end

  // Datapath: operand/sum shift registers, carry flop, bit counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      a_sr   <= a_i;
      b_sr   <= b_i;
      carry  <= cin_i;
      count  <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_nxt;
      carry  <= fa_c;
      count  <= count + CW'(1);
    end
  end

  // After the last shift the carry flop holds the carry out of bit N-1.
  assign sum_o  = sum_sr;
  assign sign_o = sum_sr[N-1];
  assign cout_o = carry;

`ifdef SERIAL_ADDER_OVF_EN
  // On the last shift, carry is the carry into bit N-1 and fa_c the carry out.
  always_ff @(posedge clk_i) begin
    if (rst_i)         ovf_o <= 1'b0;
    else if (last_bit) ovf_o <= carry ^ fa_c;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder with N=4.
module tb_serial_adder;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N-1:0] a_i, b_i;
  logic         cin_i, valid_i, ready_i;
  logic         ready_o, cout_o, sign_o, valid_o;
  logic [N-1:0] sum_o;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf_o;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  serial_adder #(.N(N)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o),
    .sign_o  (sign_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation. Edges are counted with the accepting edge as 1, so the
  // result must appear after edge N+1. hold_cycles keeps ready_i low in DONE;
  // scramble changes the operand inputs once the op is in flight.
  task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic cin, input logic [N-1:0] exp_sum, input logic exp_cout,
                       input logic exp_ovf, input int hold_cycles, input bit scramble);
    int edges;
    bit ready_low;
    logic [N-1:0] held;
    a_i = a; b_i = b; cin_i = cin; valid_i = 1'b1; ready_i = 1'b0;
    check({tag, "_ready_idle"}, 32'(ready_o), 32'd1);
    tick();
    edges = 1;
    valid_i = 1'b0;
    if (scramble) begin
      a_i = '0; b_i = '0; cin_i = 1'b1; valid_i = 1'b1;
    end
    ready_low = 1'b1;
    while (!valid_o && edges < 20) begin
      if (ready_o) ready_low = 1'b0;
      tick();
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(N + 1));
    check({tag, "_ready_busy"}, 32'(ready_low && !ready_o), 32'd1);
    check({tag, "_sum"}, 32'(sum_o), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout_o), 32'(exp_cout));
    check({tag, "_sign"}, 32'(sign_o), 32'(exp_sum[N-1]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
    held = sum_o;
    for (int k = 0; k < hold_cycles; k++) begin
      tick();
      if (sum_o !== held || valid_o !== 1'b1 || ready_o !== 1'b0) begin
        check({tag, "_hold"}, {30'd0, valid_o, ready_o}, 32'd2);
        check({tag, "_hold_sum"}, 32'(sum_o), 32'(held));
      end
    end
    if (hold_cycles > 0) check({tag, "_hold_end"}, 32'(sum_o), 32'(exp_sum));
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check({tag, "_valid_taken"}, 32'(valid_o), 32'd0);
    check({tag, "_ready_back"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; a_i = '0; b_i = '0; cin_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_sum",   32'(sum_o),   32'd0);
    check("rst_cout",  32'(cout_o),  32'd0);
    check("rst_sign",  32'(sign_o),  32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf",   32'(ovf_o),   32'd0);
`endif

    //      tag    a      b      cin   sum    cout  ovf   hold scramble
    do_op("t1", 4'd3,  4'd5,  1'b0, 4'd8,  1'b0, 1'b1, 0,  1'b0);
    do_op("t2", 4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0, 0,  1'b0);
    do_op("t3", 4'd7,  4'd8,  1'b1, 4'd0,  1'b1, 1'b0, 0,  1'b0);
    do_op("t4", 4'd6,  4'd4,  1'b1, 4'd11, 1'b0, 1'b1, 10, 1'b0);
    do_op("t5", 4'd3,  4'd5,  1'b0, 4'd8,  1'b0, 1'b1, 0,  1'b1);

    // Reset on the second SHIFT cycle aborts the op.
    a_i = 4'd3; b_i = 4'd5; cin_i = 1'b0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_ready", 32'(ready_o), 32'd1);
    check("t6_valid", 32'(valid_o), 32'd0);
    check("t6_sum",   32'(sum_o),   32'd0);
    check("t6_cout",  32'(cout_o),  32'd0);
    check("t6_sign",  32'(sign_o),  32'd0);
    do_op("t6b", 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 0, 1'b0);

    // Reset wins over a simultaneous operand handshake.
    a_i = 4'd1; b_i = 4'd1; valid_i = 1'b1; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; valid_i = 1'b0;
    tick();
    check("t7_no_accept", 32'(ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
